// File: rtl/us_cmd_arbiter.sv
// Upstream command arbiter: picks between completion requests and WR32
// requests in round-robin order, packs the winner into one 128-bit word and
// pushes it into the upstream command FIFO. A credit counter caps WR32
// commands that have been pushed but not yet reported complete.
module us_cmd_arbiter #(
  parameter int unsigned MAX_WR_OUTSTANDING = 2,
  parameter int unsigned CNT_W              = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpl_req_i,
  input  logic             cpl_with_data_i,
  input  logic [2:0]       cpl_tc_i,
  input  logic             cpl_td_i,
  input  logic             cpl_ep_i,
  input  logic [1:0]       cpl_attr_i,
  input  logic [9:0]       cpl_len_i,
  input  logic [15:0]      cpl_rid_i,
  input  logic [7:0]       cpl_tag_i,
  input  logic [7:0]       cpl_be_i,
  input  logic [5:0]       cpl_addr_i,
  output logic             cpl_ack_o,
  input  logic             wr_req_i,
  input  logic [31:0]      wr_host_addr_i,
  input  logic [4:0]       wr_len_i,
  output logic             wr_ack_o,
  input  logic             up_wr_cmd_compl_i,
  output logic             us_cmd_fifo_wr_en_o,
  output logic [127:0]     us_cmd_fifo_din_o,
  input  logic             us_cmd_fifo_full_i,
  output logic [CNT_W-1:0] wr_outstanding_o,
  output logic             credit_err_o
);

  typedef enum logic {
    ST_IDLE,
    ST_PUSH
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WR_OUTSTANDING);

  state_e             state_q;
  logic [127:0]       din_q;
  logic               cpl_ack_q;
  logic               wr_ack_q;
  logic               last_wr_q;   // 1: write source won the previous grant
  logic               push_wr_q;   // command held in din is a WR32
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               cpl_elig, wr_elig;
  logic               grant_cpl, grant_wr;
  logic               push;
  logic [127:0]       cpl_word, wr_word;

  // Eligibility, round-robin tie break and packed command words
  always_comb begin
    cpl_elig  = cpl_req_i;
    wr_elig   = wr_req_i && (cnt_q < MAX_CNT);
    grant_cpl = (state_q == ST_IDLE) && cpl_elig && (!wr_elig || last_wr_q);
    grant_wr  = (state_q == ST_IDLE) && wr_elig && (!cpl_elig || !last_wr_q);
    // A reset arriving mid-PUSH drops the pending command without pushing.
    push      = (state_q == ST_PUSH) && !us_cmd_fifo_full_i && rst_n;
    cpl_word  = {64'b0, 1'b0, cpl_with_data_i, 7'b0, cpl_tc_i, cpl_td_i,
                 cpl_ep_i, cpl_attr_i, cpl_len_i, cpl_rid_i, cpl_tag_i,
                 cpl_be_i, cpl_addr_i};
    wr_word   = {64'b0, 2'b10, wr_len_i, 25'b0, wr_host_addr_i};
  end

  // Arbitration FSM: grant in IDLE, hold the word in PUSH until the FIFO takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      din_q     <= '0;
      cpl_ack_q <= 1'b0;
      wr_ack_q  <= 1'b0;
      last_wr_q <= 1'b1;
      push_wr_q <= 1'b0;
    end else begin
      cpl_ack_q <= 1'b0;
      wr_ack_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_cpl) begin
            din_q     <= cpl_word;
            last_wr_q <= 1'b0;
            push_wr_q <= 1'b0;
            cpl_ack_q <= 1'b1;
            state_q   <= ST_PUSH;
          end else if (grant_wr) begin
            din_q     <= wr_word;
            last_wr_q <= 1'b1;
            push_wr_q <= 1'b1;
            wr_ack_q  <= 1'b1;
            state_q   <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          if (!us_cmd_fifo_full_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outstanding WR32 credit counter next state and sticky underflow flag
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (push && push_wr_q && !up_wr_cmd_compl_i) begin
      if (cnt_q < MAX_CNT) cnt_d = cnt_q + 1'b1;
    end else if (up_wr_cmd_compl_i && !(push && push_wr_q)) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  // Credit counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cpl_ack_o           = cpl_ack_q;
  assign wr_ack_o            = wr_ack_q;
  assign us_cmd_fifo_wr_en_o = push;
  assign us_cmd_fifo_din_o   = din_q;
  assign wr_outstanding_o    = cnt_q;
  assign credit_err_o        = err_q;

endmodule

// File: tb/tb_us_cmd_arbiter.sv
// Directed bench for us_cmd_arbiter with hand-computed expected values.
module tb_us_cmd_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpl_req_i, cpl_with_data_i, cpl_td_i, cpl_ep_i;
  logic [2:0]   cpl_tc_i;
  logic [1:0]   cpl_attr_i;
  logic [9:0]   cpl_len_i;
  logic [15:0]  cpl_rid_i;
  logic [7:0]   cpl_tag_i, cpl_be_i;
  logic [5:0]   cpl_addr_i;
  logic         cpl_ack_o;
  logic         wr_req_i;
  logic [31:0]  wr_host_addr_i;
  logic [4:0]   wr_len_i;
  logic         wr_ack_o;
  logic         up_wr_cmd_compl_i;
  logic         us_cmd_fifo_wr_en_o;
  logic [127:0] us_cmd_fifo_din_o;
  logic         us_cmd_fifo_full_i;
  logic [2:0]   wr_outstanding_o;
  logic         credit_err_o;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [127:0] CPL0 = 128'h0000_0000_0000_0000_0030_0040_4001_43D0;
  localparam logic [127:0] CPLD = 128'h0000_0000_0000_0000_4030_0040_4001_43D0;
  localparam logic [127:0] WR0  = 128'h0000_0000_0000_0000_8600_0000_1234_5678;

  us_cmd_arbiter #(.MAX_WR_OUTSTANDING(2), .CNT_W(3)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cpl_req_i           (cpl_req_i),
    .cpl_with_data_i     (cpl_with_data_i),
    .cpl_tc_i            (cpl_tc_i),
    .cpl_td_i            (cpl_td_i),
    .cpl_ep_i            (cpl_ep_i),
    .cpl_attr_i          (cpl_attr_i),
    .cpl_len_i           (cpl_len_i),
    .cpl_rid_i           (cpl_rid_i),
    .cpl_tag_i           (cpl_tag_i),
    .cpl_be_i            (cpl_be_i),
    .cpl_addr_i          (cpl_addr_i),
    .cpl_ack_o           (cpl_ack_o),
    .wr_req_i            (wr_req_i),
    .wr_host_addr_i      (wr_host_addr_i),
    .wr_len_i            (wr_len_i),
    .wr_ack_o            (wr_ack_o),
    .up_wr_cmd_compl_i   (up_wr_cmd_compl_i),
    .us_cmd_fifo_wr_en_o (us_cmd_fifo_wr_en_o),
    .us_cmd_fifo_din_o   (us_cmd_fifo_din_o),
    .us_cmd_fifo_full_i  (us_cmd_fifo_full_i),
    .wr_outstanding_o    (wr_outstanding_o),
    .credit_err_o        (credit_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cpl_req_i = 1'b0;
    wr_req_i = 1'b0;
    up_wr_cmd_compl_i = 1'b0;
    us_cmd_fifo_full_i = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_outs(input string tag, input logic ca, input logic wa, input logic we);
    #1;
    chk({tag, ".cpl_ack"}, 128'(cpl_ack_o), 128'(ca));
    chk({tag, ".wr_ack"}, 128'(wr_ack_o), 128'(wa));
    chk({tag, ".wr_en"}, 128'(us_cmd_fifo_wr_en_o), 128'(we));
  endtask

  initial begin
    cpl_with_data_i = 1'b0; cpl_tc_i = 3'd3; cpl_td_i = 1'b0; cpl_ep_i = 1'b0;
    cpl_attr_i = 2'd0; cpl_len_i = 10'd1; cpl_rid_i = 16'h0100; cpl_tag_i = 8'h05;
    cpl_be_i = 8'h0F; cpl_addr_i = 6'h10;
    wr_host_addr_i = 32'h1234_5678; wr_len_i = 5'h03;

    // Reset state
    do_reset();
    chk_outs("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.din", us_cmd_fifo_din_o, '0);
    chk("reset.cnt", 128'(wr_outstanding_o), 128'(0));
    chk("reset.err", 128'(credit_err_o), 128'(0));

    // Single Cpl: ack and push on cycle 2
    cpl_req_i = 1'b1;
    chk_outs("cpl.c1", 1'b0, 1'b0, 1'b0);
    step();
    chk_outs("cpl.c2", 1'b1, 1'b0, 1'b1);
    chk("cpl.c2.din", us_cmd_fifo_din_o, CPL0);
    step();
    cpl_req_i = 1'b0;
    chk_outs("cpl.c3", 1'b0, 1'b0, 1'b0);
    chk("cpl.c3.din", us_cmd_fifo_din_o, CPL0);

    // Ties after reset alternate cpl, wr, cpl, wr
    do_reset();
    cpl_with_data_i = 1'b1;
    cpl_req_i = 1'b1;
    wr_req_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_outs($sformatf("tie%0d.push", k), (k % 2) == 0, (k % 2) == 1, 1'b1);
      chk($sformatf("tie%0d.din", k), us_cmd_fifo_din_o, ((k % 2) == 0) ? CPLD : WR0);
      step();
      if (k == 3) begin cpl_req_i = 1'b0; wr_req_i = 1'b0; end
      chk_outs($sformatf("tie%0d.idle", k), 1'b0, 1'b0, 1'b0);
    end
    chk("tie.cnt", 128'(wr_outstanding_o), 128'(2));

    // Credit limit: two writes pass, third stalls, completion still served
    do_reset();
    wr_req_i = 1'b1;
    step();
    chk_outs("cred.w1", 1'b0, 1'b1, 1'b1);
    step();
    step();
    chk_outs("cred.w2", 1'b0, 1'b1, 1'b1);
    step();
    chk("cred.cnt2", 128'(wr_outstanding_o), 128'(2));
    step();
    chk_outs("cred.stall", 1'b0, 1'b0, 1'b0);
    cpl_req_i = 1'b1;
    step();
    chk_outs("cred.cpl", 1'b1, 1'b0, 1'b1);
    chk("cred.cpl.din", us_cmd_fifo_din_o, CPLD);
    step();
    cpl_req_i = 1'b0;
    up_wr_cmd_compl_i = 1'b1;
    chk_outs("cred.stall2", 1'b0, 1'b0, 1'b0);
    step();
    up_wr_cmd_compl_i = 1'b0;
    chk("cred.cnt1", 128'(wr_outstanding_o), 128'(1));
    chk_outs("cred.idle", 1'b0, 1'b0, 1'b0);
    step();
    chk_outs("cred.w3", 1'b0, 1'b1, 1'b1);
    chk("cred.w3.din", us_cmd_fifo_din_o, WR0);
    step();
    wr_req_i = 1'b0;
    chk("cred.cnt2b", 128'(wr_outstanding_o), 128'(2));

    // FIFO full for 5 cycles in PUSH
    do_reset();
    cpl_with_data_i = 1'b0;
    us_cmd_fifo_full_i = 1'b1;
    cpl_req_i = 1'b1;
    step();
    chk_outs("full.ack", 1'b1, 1'b0, 1'b0);
    chk("full.din0", us_cmd_fifo_din_o, CPL0);
    wr_req_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      cpl_req_i = 1'b0;
      chk_outs($sformatf("full.hold%0d", k), 1'b0, 1'b0, 1'b0);
      chk($sformatf("full.hold%0d.din", k), us_cmd_fifo_din_o, CPL0);
    end
    step();
    us_cmd_fifo_full_i = 1'b0;
    chk_outs("full.release", 1'b0, 1'b0, 1'b1);
    chk("full.release.din", us_cmd_fifo_din_o, CPL0);
    step();
    chk_outs("full.idle", 1'b0, 1'b0, 1'b0);
    step();
    chk_outs("full.wr", 1'b0, 1'b1, 1'b1);
    chk("full.wr.din", us_cmd_fifo_din_o, WR0);
    step();
    wr_req_i = 1'b0;

    // Simultaneous push and completion at count 1, then underflow
    do_reset();
    wr_req_i = 1'b1;
    step();
    step();
    chk("sim.cnt1", 128'(wr_outstanding_o), 128'(1));
    step();
    up_wr_cmd_compl_i = 1'b1;
    chk_outs("sim.push", 1'b0, 1'b1, 1'b1);
    step();
    wr_req_i = 1'b0;
    chk("sim.cnt_same", 128'(wr_outstanding_o), 128'(1));
    chk("sim.err0", 128'(credit_err_o), 128'(0));
    step();
    chk("sim.cnt0", 128'(wr_outstanding_o), 128'(0));
    chk("sim.err0b", 128'(credit_err_o), 128'(0));
    step();
    up_wr_cmd_compl_i = 1'b0;
    chk("under.cnt", 128'(wr_outstanding_o), 128'(0));
    chk("under.err", 128'(credit_err_o), 128'(1));
    step();
    step();
    chk("under.err_sticky", 128'(credit_err_o), 128'(1));

    // Reset while in PUSH with the FIFO full
    us_cmd_fifo_full_i = 1'b1;
    wr_req_i = 1'b1;
    step();
    chk_outs("rstp.ack", 1'b0, 1'b1, 1'b0);
    step();
    wr_req_i = 1'b0;
    rst_n = 1'b0;
    chk_outs("rstp.during", 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    us_cmd_fifo_full_i = 1'b0;
    chk_outs("rstp.after", 1'b0, 1'b0, 1'b0);
    chk("rstp.din", us_cmd_fifo_din_o, '0);
    chk("rstp.cnt", 128'(wr_outstanding_o), 128'(0));
    chk("rstp.err", 128'(credit_err_o), 128'(0));
    step();
    chk_outs("rstp.after2", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
